// File: rtl/lc3b_ewb.sv
// rtl/lc3b_ewb.sv - single-entry eviction write buffer between L1 and L2 line ports
// Optional hit/drain statistics counters are enabled by defining LC3B_EWB_STATS_EN.
module lc3b_ewb #(
  parameter int DRAIN_DELAY = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         u_read,
  input  logic         u_write,
  input  logic [15:0]  u_address,
  input  logic [127:0] u_wdata,
  output logic [127:0] u_rdata,
  output logic         u_resp,
  output logic         d_read,
  output logic         d_write,
  output logic [15:0]  d_address,
  output logic [127:0] d_wdata,
  input  logic [127:0] d_rdata,
  input  logic         d_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  drain_count
);

  localparam int CW = (DRAIN_DELAY < 1) ? 1 : $clog2(DRAIN_DELAY + 1);
  localparam logic [CW-1:0] DLY = CW'(DRAIN_DELAY);

  typedef enum logic [2:0] {IDLE, RESP, MISS_RD, DRAIN, DRAIN_WR} state_t;

  state_t         state;
  logic [127:0]   buf_line;
  logic [11:0]    buf_tag;
  logic           valid;
  logic [CW-1:0]  idle_cnt;
  logic           hit;

  // Offset bits within a line never matter to a line-granular buffer.
  logic unused_offset;
  assign unused_offset = &{1'b0, u_address[3:0]};

  assign hit = valid && (buf_tag == u_address[15:4]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      buf_line  <= '0;
      buf_tag   <= '0;
      valid     <= 1'b0;
      idle_cnt  <= '0;
      u_rdata   <= '0;
      u_resp    <= 1'b0;
      d_read    <= 1'b0;
      d_write   <= 1'b0;
      d_address <= '0;
      d_wdata   <= '0;
    end else begin
      u_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (u_read) begin
            idle_cnt <= '0;
            if (hit) begin
              u_rdata <= buf_line;
              u_resp  <= 1'b1;
              state   <= RESP;
            end else begin
              // Miss reads bypass the buffered dirty line; it drains later.
              d_read    <= 1'b1;
              d_address <= {u_address[15:4], 4'h0};
              state     <= MISS_RD;
            end
          end else if (u_write) begin
            idle_cnt <= '0;
            if (!valid || hit) begin
              buf_line <= u_wdata;
              buf_tag  <= u_address[15:4];
              valid    <= 1'b1;
              u_resp   <= 1'b1;
              state    <= RESP;
            end else begin
              d_write   <= 1'b1;
              d_address <= {buf_tag, 4'h0};
              d_wdata   <= buf_line;
              state     <= DRAIN_WR;
            end
          end else if (!valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt == DLY) begin
            d_write   <= 1'b1;
            d_address <= {buf_tag, 4'h0};
            d_wdata   <= buf_line;
            state     <= DRAIN;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        MISS_RD: begin
          if (d_resp) begin
            u_rdata <= d_rdata;
            d_read  <= 1'b0;
            u_resp  <= 1'b1;
            state   <= RESP;
          end
        end
        DRAIN: begin
          if (d_resp) begin
            d_write  <= 1'b0;
            valid    <= 1'b0;
            idle_cnt <= '0;
            state    <= IDLE;
          end
        end
        DRAIN_WR: begin
          // The victim is out; the pending writeback now takes the entry.
          if (d_resp) begin
            d_write  <= 1'b0;
            buf_line <= u_wdata;
            buf_tag  <= u_address[15:4];
            valid    <= 1'b1;
            u_resp   <= 1'b1;
            state    <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LC3B_EWB_STATS_EN
  logic        hit_evt;
  logic        drain_evt;
  logic [15:0] hit_cnt_q;
  logic [15:0] drain_cnt_q;

  assign hit_evt   = (state == IDLE) && u_read && hit;
  assign drain_evt = ((state == DRAIN) || (state == DRAIN_WR)) && d_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != 16'hFFFF))
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (drain_evt && (drain_cnt_q != 16'hFFFF))
        drain_cnt_q <= drain_cnt_q + 16'd1;
    end
  end

  assign hit_count   = hit_cnt_q;
  assign drain_count = drain_cnt_q;
`else
  assign hit_count   = 16'h0000;
  assign drain_count = 16'h0000;
`endif

endmodule
